// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write-only LCD controller.
// LCD_INIT_EN adds the power-on init states to the state enum.
package lcd_pkg;

  localparam int CNT_W = 20;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Power-on sequence: 8-bit/2-line, display on, clear, entry mode increment
  localparam logic [7:0] INIT_FUNC_SET = 8'h38;
  localparam logic [7:0] INIT_DISP_ON  = 8'h0C;
  localparam logic [7:0] INIT_CLEAR    = 8'h01;
  localparam logic [7:0] INIT_ENTRY    = 8'h06;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
`ifdef LCD_INIT_EN
    ,
    ST_INIT_WAIT,
    ST_INIT_CMD
`endif
  } state_t;

  // Clear and home need the long execution wait
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return !rs && (d == CMD_CLEAR || d == CMD_HOME);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Down-counter shared by every timed state; done while the count sits at zero.
module lcd_timer
  import lcd_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)          cnt <= '0;
    else if (load)         cnt <= value;
    else if (cnt != '0)    cnt <= cnt - CNT_W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write-only bus controller: SETUP/PULSE/HOLD/WAIT per byte.
// Define LCD_INIT_EN to run the power-on wait and init command sequence.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int EN_CYC    = 25,
  parameter int HOLD_CYC  = 2,
  parameter int EXEC_CYC  = 2000,
  parameter int CLR_CYC   = 82000,
  parameter int POR_CYC   = 750000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req_vld,
  input  logic       i_req_rs,
  input  logic [7:0] i_req_data,
  input  logic       i_lcd_on,
  output logic       o_req_rdy,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic       o_lcd_on
);

`ifdef LCD_INIT_EN
  localparam state_t RST_ST = ST_INIT_WAIT;
  // The arming cycle spends one count, so load two short
  localparam int POR_LOAD = (POR_CYC > 1) ? POR_CYC - 2 : 0;
`else
  localparam state_t RST_ST = ST_IDLE;
`endif

  state_t           state, nxt;
  logic [7:0]       data_q;
  logic             rs_q, en_q, on_q, en_nxt;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_val;

`ifdef LCD_INIT_EN
  logic [2:0] idx;
  logic       por_armed;
  logic [7:0] rom_byte;

  always_comb begin
    rom_byte = INIT_FUNC_SET;
    case (idx[1:0])
      2'd0: rom_byte = INIT_FUNC_SET;
      2'd1: rom_byte = INIT_DISP_ON;
      2'd2: rom_byte = INIT_CLEAR;
      2'd3: rom_byte = INIT_ENTRY;
      default: rom_byte = INIT_FUNC_SET;
    endcase
  end
`endif

  lcd_timer u_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .load    (tmr_load),
    .value   (tmr_val),
    .done    (tmr_done)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= RST_ST;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (i_req_vld) nxt = ST_SETUP;
      ST_SETUP: if (tmr_done)  nxt = ST_PULSE;
      ST_PULSE: if (tmr_done)  nxt = ST_HOLD;
      ST_HOLD:  if (tmr_done)  nxt = ST_WAIT;
`ifdef LCD_INIT_EN
      ST_WAIT:      if (tmr_done) nxt = (idx < 3'd4) ? ST_INIT_CMD : ST_IDLE;
      ST_INIT_WAIT: if (por_armed && tmr_done) nxt = ST_INIT_CMD;
      ST_INIT_CMD:  nxt = ST_SETUP;
`else
      ST_WAIT:  if (tmr_done)  nxt = ST_IDLE;
`endif
      default:  nxt = ST_IDLE;
    endcase
  end

  // Counter reload on every state change, sized for the state being entered
  always_comb begin
    tmr_load = (nxt != state);
    tmr_val  = '0;
    case (nxt)
      ST_SETUP: tmr_val = CNT_W'(SETUP_CYC - 1);
      ST_PULSE: tmr_val = CNT_W'(EN_CYC - 1);
      ST_HOLD:  tmr_val = CNT_W'(HOLD_CYC - 1);
      ST_WAIT:  tmr_val = is_long_cmd(rs_q, data_q) ? CNT_W'(CLR_CYC - 1)
                                                    : CNT_W'(EXEC_CYC - 1);
      default:  tmr_val = '0;
    endcase
`ifdef LCD_INIT_EN
    if (state == ST_INIT_WAIT && !por_armed) begin
      tmr_load = 1'b1;
      tmr_val  = CNT_W'(POR_LOAD);
    end
`endif
  end

  always_comb begin
    o_req_rdy = (state == ST_IDLE);
    en_nxt    = (nxt == ST_PULSE);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      data_q <= 8'h00;
      rs_q   <= 1'b0;
      en_q   <= 1'b0;
`ifdef LCD_INIT_EN
      idx       <= 3'd0;
      por_armed <= 1'b0;
`endif
    end else begin
      en_q <= en_nxt;
      if (state == ST_IDLE && i_req_vld) begin
        data_q <= i_req_data;
        rs_q   <= i_req_rs;
      end
`ifdef LCD_INIT_EN
      if (state == ST_INIT_WAIT) por_armed <= 1'b1;
      if (state == ST_INIT_CMD) begin
        data_q <= rom_byte;
        rs_q   <= 1'b0;
        idx    <= idx + 3'd1;
      end
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) on_q <= 1'b0;
    else          on_q <= i_lcd_on;
  end

  assign o_lcd_data = data_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = en_q;
  assign o_lcd_on   = on_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened timing (2/3/1/5/10/20 cycles).
// Build with LCD_INIT_EN to exercise the power-on init sequence instead of the reset-abort case.
module tb_lcd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_vld, req_rs, lcd_on_in;
  logic [7:0] req_data;
  logic       rdy, lcd_rs, lcd_rw, lcd_en, lcd_on;
  logic [7:0] lcd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcd_ctrl #(
    .SETUP_CYC (2), .EN_CYC (3), .HOLD_CYC (1),
    .EXEC_CYC  (5), .CLR_CYC (10), .POR_CYC (20)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_req_vld  (req_vld),
    .i_req_rs   (req_rs),
    .i_req_data (req_data),
    .i_lcd_on   (lcd_on_in),
    .o_req_rdy  (rdy),
    .o_lcd_data (lcd_data),
    .o_lcd_rs   (lcd_rs),
    .o_lcd_rw   (lcd_rw),
    .o_lcd_en   (lcd_en),
    .o_lcd_on   (lcd_on)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (!rdy && n < 200) begin
      tick();
      n++;
    end
    chk(tag, rdy, 1);
  endtask

  // One transaction; the request inputs are scrambled right after accept
  task automatic run_req(input logic rs, input logic [7:0] d, input int exp_low, input string tag);
    int low = 0, en_cnt = 0, first = -1, bad = 0;
    wait_rdy({tag, "_rdy"});
    req_vld = 1'b1; req_rs = rs; req_data = d;
    tick();
    req_vld = 1'b0; req_rs = ~rs; req_data = 8'hFF;
    for (int c = 0; c < 40 && !rdy; c++) begin
      low++;
      if (lcd_en) begin
        en_cnt++;
        if (first < 0) first = c;
      end
      if (lcd_data !== d || lcd_rs !== rs || lcd_rw !== 1'b0) bad++;
      tick();
    end
    chk({tag, "_rdy_low"}, low, exp_low);
    chk({tag, "_en_width"}, en_cnt, 3);
    chk({tag, "_en_start"}, first, 2);
    chk({tag, "_bus_stable"}, bad, 0);
    chk({tag, "_data_kept"}, {lcd_rs, lcd_data}, {rs, d});
  endtask

  initial begin
    rst_n = 1'b0; req_vld = 1'b0; req_rs = 1'b0; req_data = 8'h00; lcd_on_in = 1'b0;
    tick(); tick();
    chk("rst_en",   lcd_en,   0);
    chk("rst_rs",   lcd_rs,   0);
    chk("rst_rw",   lcd_rw,   0);
    chk("rst_on",   lcd_on,   0);
    chk("rst_data", lcd_data, 8'h00);
`ifdef LCD_INIT_EN
    chk("rst_rdy",  rdy,      0);
`else
    chk("rst_rdy",  rdy,      1);
`endif
    @(negedge clk) rst_n = 1'b1;
    tick();

`ifdef LCD_INIT_EN
    begin
      logic [7:0] seen [4];
      logic [7:0] exp_cmd [4];
      int n = 0, first = -1, wbad = 0, rsbad = 0, w = 0;
      logic prev = 1'b0;
      exp_cmd[0] = 8'h38; exp_cmd[1] = 8'h0C; exp_cmd[2] = 8'h01; exp_cmd[3] = 8'h06;
      // Request pending through the whole init; it must wait for rdy
      req_vld = 1'b1; req_rs = 1'b1; req_data = 8'h99;
      for (int s = 0; s < 400 && !rdy; s++) begin
        if (lcd_en && !prev) begin
          if (n < 4) seen[n] = lcd_data;
          if (n == 0) first = s;
          if (lcd_rs !== 1'b0) rsbad++;
          n++;
          w = 0;
        end
        if (lcd_en) w++;
        if (!lcd_en && prev && w != 3) wbad++;
        prev = lcd_en;
        tick();
      end
      // 20 power-on cycles, one command-fetch cycle, 2 setup cycles
      chk("init_first_en", first, 22);
      chk("init_pulses", n, 4);
      for (int i = 0; i < 4; i++) chk($sformatf("init_cmd%0d", i), seen[i], exp_cmd[i]);
      chk("init_width", wbad, 0);
      chk("init_rs", rsbad, 0);
      chk("init_rdy", rdy, 1);
      chk("init_not_taken", lcd_data, 8'h06);
      tick();
      chk("init_req_taken", {rdy, lcd_data}, {1'b0, 8'h99});
      req_vld = 1'b0;
      wait_rdy("init_req_done");
    end
`else
    chk("rdy_after_rst", rdy, 1);
`endif

    lcd_on_in = 1'b1;
    #1;
    chk("on_not_comb", lcd_on, 0);
    tick();
    chk("on_latency", lcd_on, 1);

    run_req(1'b1, 8'h41, 11, "data41");
    run_req(1'b0, 8'h01, 16, "clear");
    run_req(1'b1, 8'h01, 11, "data01");
    run_req(1'b0, 8'h02, 16, "home");
    run_req(1'b0, 8'h38, 11, "cmd38");

    begin
      int low = 0, bad = 0;
      req_vld = 1'b1; req_rs = 1'b1; req_data = 8'h30;
      tick();
      req_data = 8'hFF;
      for (int c = 0; c < 40 && !rdy; c++) begin
        low++;
        if (lcd_data !== 8'h30) bad++;
        if (c == 5) req_data = 8'h31;
        tick();
      end
      chk("b2b_low", low, 11);
      chk("b2b_first_stable", bad, 0);
      tick();
      chk("b2b_second_taken", {rdy, lcd_data}, {1'b0, 8'h31});
      req_vld = 1'b0;
      bad = 0;
      for (int c = 0; c < 40 && !rdy; c++) begin
        if (lcd_data == 8'hFF) bad++;
        tick();
      end
      chk("b2b_no_ff", bad, 0);
      chk("b2b_done", {rdy, lcd_data}, {1'b1, 8'h31});
    end

`ifndef LCD_INIT_EN
    begin
      int n = 0, stray = 0;
      wait_rdy("abort_rdy");
      req_vld = 1'b1; req_rs = 1'b1; req_data = 8'h55;
      tick();
      req_vld = 1'b0;
      while (!lcd_en && n < 20) begin
        tick();
        n++;
      end
      chk("abort_in_pulse", lcd_en, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_en_now", lcd_en, 0);
      chk("abort_outs", {lcd_rs, lcd_rw, lcd_on, lcd_data}, 11'h000);
      chk("abort_rdy_in_rst", rdy, 1);
      tick(); tick();
      @(negedge clk) rst_n = 1'b1;
      tick();
      chk("abort_rdy_after", rdy, 1);
      chk("abort_on_back", lcd_on, 1);
      for (int c = 0; c < 8; c++) begin
        if (lcd_en || !rdy) stray++;
        tick();
      end
      chk("abort_no_replay", stray, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2: RS/DATA setup cycles before EN rises.
REQ-002 SHALL have parameter EN_CYC, default 25: EN high width in cycles (500 ns at 50 MHz).
REQ-003 SHALL have parameter HOLD_CYC, default 2: RS/DATA hold cycles after EN falls.
REQ-004 SHALL have parameter EXEC_CYC, default 2000: post-write busy wait for normal commands and data (40 us).
REQ-005 SHALL have parameter CLR_CYC, default 82000: post-write busy wait for clear (0x01) and home (0x02) commands (1.64 ms).
REQ-006 SHALL have parameter POR_CYC, default 750000: power-on wait (15 ms), used only with LCD_INIT_EN.
REQ-007 SHALL have port i_clk, input, 1: clock, rising edge.
REQ-008 SHALL have port i_reset, input, 1: reset, asynchronous, active-low.
REQ-009 SHALL have port i_req_vld, input, 1: request valid from the core's LCD register path.
REQ-010 SHALL have port i_req_rs, input, 1: register select (0 = command, 1 = data).
REQ-011 SHALL have port i_req_data, input, 8: byte to write.
REQ-012 SHALL have port i_lcd_on, input, 1: panel power/backlight request.
REQ-013 SHALL have port o_req_rdy, output, 1: controller can accept a request.
REQ-014 SHALL have ports o_lcd_data (8), o_lcd_rs (1), o_lcd_rw (1), o_lcd_en (1), o_lcd_on (1), all outputs: HD44780 pins.

Function
REQ-015 SHALL use states IDLE, SETUP, PULSE, HOLD, WAIT (plus INIT_WAIT, INIT_CMD with LCD_INIT_EN).
REQ-016 SHALL accept a request on a rising edge where i_req_vld && o_req_rdy, latching i_req_rs and i_req_data, and go IDLE -> SETUP.
REQ-017 SHALL drive o_req_rdy high only in IDLE; it is decoded from state, no extra latency.
REQ-018 SHALL remain in SETUP, PULSE, HOLD and WAIT for exactly SETUP_CYC, EN_CYC, HOLD_CYC and the selected wait cycles respectively, then advance SETUP->PULSE->HOLD->WAIT->IDLE.
REQ-019 SHALL assert o_lcd_en only in PULSE; o_lcd_en is registered and glitch-free.
REQ-020 SHALL drive o_lcd_data/o_lcd_rs from the latched values from SETUP through WAIT and keep the last values in IDLE.
REQ-021 SHALL select CLR_CYC when the latched rs=0 and data is 0x01 or 0x02, otherwise EXEC_CYC.
REQ-022 SHALL tie o_lcd_rw to 0 (write-only; no busy-flag reads).
REQ-023 SHALL register i_lcd_on into o_lcd_on with 1-cycle latency, independent of the FSM.
REQ-024 SHALL ignore changes on the request inputs while not in IDLE; a request accepted on the edge entering IDLE gives zero-gap back-to-back operation.
REQ-025 SHALL use a single 20-bit down-counter loaded with N-1 on state entry; all parameters are >=1 and <2^20.

Reset
REQ-026 SHALL, while i_reset=0, force state IDLE (INIT_WAIT with LCD_INIT_EN), counter 0, o_lcd_en/rs/rw/on = 0, o_lcd_data = 0x00.
REQ-027 SHALL abort any transaction immediately on reset, dropping o_lcd_en in the same instant; the lost request is not replayed.

Configuration
REQ-028 SHALL, with LCD_INIT_EN defined, wait POR_CYC cycles after reset, then send commands 0x38, 0x0C, 0x01, 0x06 (rs=0) using the normal SETUP/PULSE/HOLD/WAIT timing, holding o_req_rdy low until 0x06's WAIT completes.
REQ-029 SHALL, without LCD_INIT_EN, omit the init states and ROM and enter IDLE directly from reset.

Structure
REQ-030 SHALL place the state enum, the counter width (20), CMD_CLEAR/CMD_HOME and the four init command constants in package lcd_pkg.
REQ-031 SHALL implement the counter as sub-module lcd_timer (load, value, done); all other logic stays in lcd_ctrl.

Verification (SETUP=2, EN=3, HOLD=1, EXEC=5, CLR=10, POR=20)
REQ-032 SHALL verify: accept rs=1 data=0x41 -> o_lcd_en high exactly 3 cycles starting 2 cycles after accept, data 0x41 rs=1 stable throughout, o_req_rdy low 11 cycles.
REQ-033 SHALL verify: rs=0 data=0x01 -> o_req_rdy low 16 cycles; rs=1 data=0x01 -> low 11 cycles.
REQ-034 SHALL verify: i_req_vld held high, data 0x30 then 0x31 -> second accepted on the edge o_req_rdy returns; data driven to 0xFF mid-operation never appears on o_lcd_data.
REQ-035 SHALL verify: i_reset low during PULSE -> o_lcd_en 0 immediately, all outputs at reset values, o_req_rdy 1 one cycle after release (macro off).
REQ-036 SHALL verify: with LCD_INIT_EN -> 20 idle cycles, then 0x38, 0x0C, 0x01, 0x06 each with one 3-cycle EN pulse; a request during init is not accepted until o_req_rdy rises.
